// File: rtl/regfile_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_port_arbiter_if
//  Description : Bundles the request/response handshake of the two register
//                file requesters (core = 0, debug = 1) with the register file
//                bus (one-hot enables, store strobes, write data, read buses).
//                  slave  : used by regfile_port_arbiter
//                  master : used by the requesters and register array side
//                Packed per-requester fields: requester i at [i*W +: W].
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_port_arbiter_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
);
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_we;
   logic [2*AW-1:0]   req_rs1;
   logic [2*AW-1:0]   req_rs2;
   logic [2*AW-1:0]   req_rd;
   logic [2*XLEN-1:0] req_wdata;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [XLEN-1:0]   rsp_a;
   logic [XLEN-1:0]   rsp_b;
   logic [NREG-1:0]   reg_enable_a;
   logic [NREG-1:0]   reg_enable_b;
   logic [NREG-1:0]   reg_store;
   logic [XLEN-1:0]   reg_wdata;
   logic [XLEN-1:0]   bus_a;
   logic [XLEN-1:0]   bus_b;

   modport slave (
      input  req_valid, req_we, req_rs1, req_rs2, req_rd, req_wdata,
      input  rsp_ready, bus_a, bus_b,
      output req_ready, rsp_valid, rsp_a, rsp_b,
      output reg_enable_a, reg_enable_b, reg_store, reg_wdata
   );

   modport master (
      output req_valid, req_we, req_rs1, req_rs2, req_rd, req_wdata,
      output rsp_ready, bus_a, bus_b,
      input  req_ready, rsp_valid, rsp_a, rsp_b,
      input  reg_enable_a, reg_enable_b, reg_store, reg_wdata
   );
endinterface
`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_port_arbiter
//  Description : Round-robin arbiter sequencing all accesses to a tri-state
//                bussed register file shared by the core (0) and debug (1).
//                Each transaction reads rs1 on bus A, rs2 on bus B and
//                optionally writes rd, then returns the captured values via a
//                valid/ready response. IDLE -> ACCESS (1 cycle) -> RESP.
//  Ports       : clk      - clock
//                reset_n  - asynchronous active-low reset
//                bus      - regfile_port_arbiter_if.slave (requests,
//                           responses, register enables/store, read buses)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_port_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  wire logic              clk,
   input  wire logic              reset_n,
   regfile_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rr_last;
   logic              r_owner;
   logic              r_we;
   logic [AW-1:0]     r_rs1;
   logic [AW-1:0]     r_rs2;
   logic [AW-1:0]     r_rd;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_rsp_a;
   logic [XLEN-1:0]   r_rsp_b;

   logic              w_grant;
   logic              w_accept;
   logic [1:0]        w_req_ready;
   logic [NREG-1:0]   w_en_a;
   logic [NREG-1:0]   w_en_b;
   logic [NREG-1:0]   w_store;
   logic [AW-1:0]     w_sel_rs1;
   logic [AW-1:0]     w_sel_rs2;
   logic [AW-1:0]     w_sel_rd;
   logic [XLEN-1:0]   w_sel_wdata;

   // x0 is hardwired: index 0 never produces an enable or store bit.
   function automatic logic [NREG-1:0] f_onehot(input logic [AW-1:0] idx);
      if (idx == '0) begin
         f_onehot = '0;
      end else begin
         f_onehot = NREG'(1) << idx;
      end
   endfunction

   // Prefer the requester that did not win last time.
   always_comb begin
      if (bus.req_valid[~r_rr_last]) begin
         w_grant = ~r_rr_last;
      end else begin
         w_grant = r_rr_last;
      end
   end

   assign w_sel_rs1   = w_grant ? bus.req_rs1[2*AW-1:AW]       : bus.req_rs1[AW-1:0];
   assign w_sel_rs2   = w_grant ? bus.req_rs2[2*AW-1:AW]       : bus.req_rs2[AW-1:0];
   assign w_sel_rd    = w_grant ? bus.req_rd[2*AW-1:AW]        : bus.req_rd[AW-1:0];
   assign w_sel_wdata = w_grant ? bus.req_wdata[2*XLEN-1:XLEN] : bus.req_wdata[XLEN-1:0];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and outputs. Enables and ready are qualified with reset_n so
   // they drop the instant reset is asserted, without waiting for state.
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 2'b00;
      w_en_a      = '0;
      w_en_b      = '0;
      w_store     = '0;
      case (r_state)
         IDLE: begin
            if (reset_n && bus.req_valid[w_grant]) begin
               w_req_ready[w_grant] = 1'b1;
               w_state_nxt          = ACCESS;
            end
         end
         ACCESS: begin
            w_state_nxt = RESP;
            if (reset_n) begin
               w_en_a = f_onehot(r_rs1);
               w_en_b = f_onehot(r_rs2);
               if (r_we) begin
                  w_store = f_onehot(r_rd);
               end
            end
         end
         RESP: begin
            if (bus.rsp_ready[r_owner]) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_accept = |w_req_ready;

   // Transaction latch and response capture. Reads sample the bus on the
   // same edge that performs the store, so they see the pre-write value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_last <= 1'b1;
         r_owner   <= 1'b0;
         r_we      <= 1'b0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_wdata   <= '0;
         r_rsp_a   <= '0;
         r_rsp_b   <= '0;
      end else begin
         if (w_accept) begin
            r_rr_last <= w_grant;
            r_owner   <= w_grant;
            r_we      <= bus.req_we[w_grant];
            r_rs1     <= w_sel_rs1;
            r_rs2     <= w_sel_rs2;
            r_rd      <= w_sel_rd;
            r_wdata   <= w_sel_wdata;
         end
         if (r_state == ACCESS) begin
            // An undriven bus floats; x0 reads never sample it.
            r_rsp_a <= (r_rs1 == '0) ? '0 : bus.bus_a;
            r_rsp_b <= (r_rs2 == '0) ? '0 : bus.bus_b;
         end
      end
   end

   assign bus.req_ready    = w_req_ready;
   assign bus.rsp_valid    = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_a        = r_rsp_a;
   assign bus.rsp_b        = r_rsp_b;
   assign bus.reg_enable_a = w_en_a;
   assign bus.reg_enable_b = w_en_b;
   assign bus.reg_store    = w_store;
   assign bus.reg_wdata    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_port_arbiter
//  Description : Directed bench for regfile_port_arbiter. Models a 32-entry
//                register array on the tri-state buses (an undriven bus reads
//                a poison pattern) and checks handshakes, data and enables.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_port_arbiter;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam logic [XLEN-1:0] c_float = 32'hF10A_7F10;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   regfile_port_arbiter_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_if ();

   regfile_port_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u_if)
   );

   // Register array model
   logic [XLEN-1:0] regs [NREG] = '{default: '0};

   always @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (u_if.reg_store[i]) regs[i] <= u_if.reg_wdata;
      end
   end

   always_comb begin
      u_if.bus_a = c_float;
      u_if.bus_b = c_float;
      for (int i = 0; i < NREG; i++) begin
         if (u_if.reg_enable_a[i]) u_if.bus_a = regs[i];
         if (u_if.reg_enable_b[i]) u_if.bus_b = regs[i];
      end
   end

   // Enable monitor
   int              store_cnt;
   logic [NREG-1:0] store_val;
   logic [NREG-1:0] enb_seen;
   int              onehot_viol;

   initial begin
      store_cnt   = 0;
      store_val   = '0;
      enb_seen    = '0;
      onehot_viol = 0;
   end

   always @(negedge clk) begin
      if (u_if.reg_store != '0) begin
         store_cnt = store_cnt + 1;
         store_val = u_if.reg_store;
      end
      enb_seen = enb_seen | u_if.reg_enable_b;
      if ($countones(u_if.reg_enable_a) > 1 || $countones(u_if.reg_enable_b) > 1 ||
          $countones(u_if.reg_store) > 1)
         onehot_viol = onehot_viol + 1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_slot(input int who, input logic we, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                           input logic [XLEN-1:0] wd);
      u_if.req_we[who]                 = we;
      u_if.req_rs1[who*AW +: AW]       = rs1;
      u_if.req_rs2[who*AW +: AW]       = rs2;
      u_if.req_rd[who*AW +: AW]        = rd;
      u_if.req_wdata[who*XLEN +: XLEN] = wd;
   endtask

   // Bounded wait for req_ready[who]; returns with ok=0 on timeout.
   task automatic wait_grant(input int who, input string tag, output bit ok);
      int n;
      n = 0;
      while (!u_if.req_ready[who] && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = u_if.req_ready[who];
      if (!ok) check({tag, "_grant_timeout"}, 64'd0, 64'd1);
   endtask

   // Full transaction with rsp_ready already high; called at a negedge.
   task automatic run_txn(input int who, input string tag,
                          output logic [XLEN-1:0] a, output logic [XLEN-1:0] b);
      bit ok;
      a = '0;
      b = '0;
      u_if.req_valid[who] = 1'b1;
      #1;
      wait_grant(who, tag, ok);
      if (!ok) begin
         u_if.req_valid[who] = 1'b0;
         return;
      end
      @(posedge clk);
      #1 u_if.req_valid[who] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({tag, "_rsp_valid"}, 64'(u_if.rsp_valid), 64'(2'b01 << who));
      a = u_if.rsp_a;
      b = u_if.rsp_b;
      @(negedge clk);
      check({tag, "_rsp_done"}, 64'(u_if.rsp_valid), 64'd0);
   endtask

   logic [XLEN-1:0] a, b, a0, b0;
   logic [1:0]      gq [$];
   logic [1:0]      rq [$];
   logic [XLEN-1:0] aq [$];
   bit              ok;
   int              nr, cyc, unstable, ready_seen;

   initial begin
      reset_n        = 1'b0;
      u_if.req_valid = 2'b11;
      u_if.rsp_ready = 2'b11;
      u_if.req_we    = '0;
      u_if.req_rs1   = '0;
      u_if.req_rs2   = '0;
      u_if.req_rd    = '0;
      u_if.req_wdata = '0;
      set_slot(0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h0000_0011);
      set_slot(1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

      // Reset with both requesters pending
      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(u_if.req_ready), 64'd0);
      check("rst_en_a", 64'(u_if.reg_enable_a), 64'd0);
      check("rst_en_b", 64'(u_if.reg_enable_b), 64'd0);
      check("rst_store", 64'(u_if.reg_store), 64'd0);
      check("rst_rsp_valid", 64'(u_if.rsp_valid), 64'd0);
      check("rst_rsp_a", 64'(u_if.rsp_a), 64'd0);
      check("rst_rsp_b", 64'(u_if.rsp_b), 64'd0);
      reset_n = 1'b1;
      #1;
      check("first_grant_core", 64'(u_if.req_ready), 64'd1);

      // Core preloads x7 = 0x11, then debug reads x0/x0
      run_txn(0, "preload_x7", a, b);
      run_txn(1, "dbg_read_x0", a, b);
      check("dbg_read_x0_a", 64'(a), 64'd0);
      check("dbg_read_x0_b", 64'(b), 64'd0);

      // Core writes x5
      store_cnt = 0;
      set_slot(0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF);
      run_txn(0, "wr_x5", a, b);
      check("wr_x5_store_cnt", 64'(store_cnt), 64'd1);
      check("wr_x5_store_val", 64'(store_val), 64'h20);

      // Core reads x5 on A, x0 on B
      enb_seen = '0;
      set_slot(0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
      run_txn(0, "rd_x5", a, b);
      check("rd_x5_a", 64'(a), 64'hDEAD_BEEF);
      check("rd_x5_b", 64'(b), 64'd0);
      check("rd_x5_enb_idle", 64'(enb_seen), 64'd0);

      // Read and write x7 in one transaction: old value returned
      set_slot(0, 1'b1, 5'd7, 5'd0, 5'd7, 32'h0000_0022);
      run_txn(0, "rmw_x7", a, b);
      check("rmw_x7_old", 64'(a), 64'h11);
      set_slot(0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h0);
      run_txn(0, "rd_x7", a, b);
      check("rd_x7_new_b", 64'(b), 64'h22);
      check("rd_x7_a_x0", 64'(a), 64'd0);

      // Debug writes x0: no store, response still issues
      store_cnt = 0;
      set_slot(1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
      run_txn(1, "wr_x0", a, b);
      check("wr_x0_no_store", 64'(store_cnt), 64'd0);
      set_slot(1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
      run_txn(1, "rd_x0", a, b);
      check("rd_x0_a", 64'(a), 64'd0);
      check("rd_x0_b", 64'(b), 64'd0);

      // Fairness: both valid for 6 transactions
      set_slot(0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
      set_slot(1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
      u_if.req_valid = 2'b11;
      nr  = 0;
      cyc = 0;
      #1;
      while (nr < 6 && cyc < 60) begin
         if (u_if.req_ready != 2'b00) gq.push_back(u_if.req_ready);
         if (u_if.rsp_valid != 2'b00) begin
            rq.push_back(u_if.rsp_valid);
            aq.push_back(u_if.rsp_a);
            nr++;
         end
         if (nr < 6) @(negedge clk);
         cyc++;
      end
      @(posedge clk);
      #1 u_if.req_valid = 2'b00;
      @(negedge clk);
      check("fair_rsp_count", 64'(nr), 64'd6);
      check("fair_grant_count", 64'(gq.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("fair_grant%0d", i), 64'(gq[i]), (i % 2) ? 64'd2 : 64'd1);
         check($sformatf("fair_rspv%0d", i), 64'(rq[i]), (i % 2) ? 64'd2 : 64'd1);
         check($sformatf("fair_rspa%0d", i), 64'(aq[i]), (i % 2) ? 64'h22 : 64'hDEAD_BEEF);
      end

      // Backpressure on the core response, debug pending meanwhile
      set_slot(0, 1'b0, 5'd5, 5'd7, 5'd0, 32'h0);
      set_slot(1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
      u_if.rsp_ready = 2'b10;
      u_if.req_valid[0] = 1'b1;
      #1;
      wait_grant(0, "bp", ok);
      @(posedge clk);
      #1;
      u_if.req_valid[0] = 1'b0;
      u_if.req_valid[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_rsp_valid", 64'(u_if.rsp_valid), 64'd1);
      a0 = u_if.rsp_a;
      b0 = u_if.rsp_b;
      unstable   = 0;
      ready_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (u_if.rsp_valid != 2'b01 || u_if.rsp_a != a0 || u_if.rsp_b != b0) unstable++;
         if (u_if.req_ready != 2'b00) ready_seen++;
      end
      check("bp_a", 64'(a0), 64'hDEAD_BEEF);
      check("bp_b", 64'(b0), 64'h22);
      check("bp_stable", 64'(unstable), 64'd0);
      check("bp_no_ready", 64'(ready_seen), 64'd0);
      u_if.rsp_ready = 2'b11;
      @(negedge clk);
      check("bp_release_rspv", 64'(u_if.rsp_valid), 64'd0);
      check("bp_release_grant", 64'(u_if.req_ready), 64'd2);
      run_txn(1, "bp_dbg", a, b);
      check("bp_dbg_a", 64'(a), 64'd0);

      // Reset asserted during ACCESS
      set_slot(0, 1'b1, 5'd5, 5'd0, 5'd9, 32'h0000_0099);
      u_if.req_valid[0] = 1'b1;
      #1;
      wait_grant(0, "rst_acc", ok);
      @(posedge clk);
      #1 u_if.req_valid[0] = 1'b0;
      #1;
      check("acc_store_live", 64'(u_if.reg_store), 64'h200);
      check("acc_en_a_live", 64'(u_if.reg_enable_a), 64'h20);
      reset_n = 1'b0;
      #1;
      check("acc_rst_en_a", 64'(u_if.reg_enable_a), 64'd0);
      check("acc_rst_store", 64'(u_if.reg_store), 64'd0);
      @(negedge clk);
      check("acc_rst_rspv", 64'(u_if.rsp_valid), 64'd0);
      reset_n = 1'b1;
      set_slot(0, 1'b0, 5'd9, 5'd5, 5'd0, 32'h0);
      run_txn(0, "post_rst", a, b);
      check("post_rst_x9", 64'(a), 64'd0);
      check("post_rst_x5", 64'(b), 64'hDEAD_BEEF);
      check("onehot_viol", 64'(onehot_viol), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
Sequences all accesses to the tri-state-bussed register file (NREG register instances sharing read buses A/B). Arbitrates between two requesters, the core (index 0) and the debug port (index 1), using round-robin. Drives the per-register one-hot read-enable and store lines, captures the bus values, and returns them through a valid/ready response. Each transaction reads rs1 on bus A and rs2 on bus B, and optionally writes rd.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (x0..x31)
AW, 5, register index width, equal to clog2(NREG)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  2  request valid, per requester
req_ready  out  2  request accepted this cycle, per requester
req_we  in  2  write rd in this transaction
req_rs1  in  2*AW  bus-A read index, packed (requester i at [i*AW +: AW])
req_rs2  in  2*AW  bus-B read index, packed
req_rd  in  2*AW  write index, packed
req_wdata  in  2*XLEN  write data, packed
rsp_valid  out  2  response valid, per requester
rsp_ready  in  2  response consumed
rsp_a  out  XLEN  rs1 value
rsp_b  out  XLEN  rs2 value
reg_enable_a  out  NREG  one-hot bus-A output enable
reg_enable_b  out  NREG  one-hot bus-B output enable
reg_store  out  NREG  one-hot store strobe
reg_wdata  out  XLEN  shared write data to all registers
bus_a  in  XLEN  shared read bus A
bus_b  in  XLEN  shared read bus B

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous and active-low. During reset:
  - state = IDLE, rr_last = 1, so the core wins the first tie.
  - rsp_valid = 0, rsp_a = rsp_b = 0.
  - reg_enable_a/b = 0 and reg_store = 0, forced immediately (not at the next edge).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - grant = the requester other than rr_last if it is valid; otherwise the valid one.
  - req_ready[grant] = 1 for that cycle only; req_ready is 0 in every other state.
  - On valid & ready, latch the index, we, rs1, rs2, rd and wdata of the granted requester, set rr_last = grant, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - reg_enable_a = onehot(rs1) and reg_enable_b = onehot(rs2).
  - reg_store = onehot(rd) if we; reg_wdata = latched wdata.
  - At the closing edge, capture bus_a into rsp_a and bus_b into rsp_b, then go to RESP.
  - Read-before-write: the register updates on the same edge, so the reads return the old value.
- x0 handling:
  - Index 0 never asserts reg_enable_a, reg_enable_b or reg_store bit 0.
  - The captured value for an index-0 read is forced to 0. The floating bus is never sampled.
- RESP:
  - rsp_valid[index] = 1; rsp_a and rsp_b are held stable.
  - On rsp_ready[index], rsp_valid drops and the FSM returns to IDLE. rsp_ready on the non-owning bit is ignored.
- Enable invariants: reg_enable_a, reg_enable_b and reg_store are each at most one-hot, and all zero outside ACCESS.
- Latency and throughput:
  - Accept edge T, ACCESS during T+1, rsp_valid from T+2.
  - Minimum 3 cycles per transaction; no overlap between transactions.
- No new grant is issued while in ACCESS or RESP; pending requests simply wait.
- Reset asserted mid-ACCESS or mid-RESP: the transaction is abandoned. A write is not guaranteed unless its clock edge occurred before reset_n fell.

Test Plan:
- Reset: hold reset_n=0 with req_valid=2'b11 -> req_ready=0, reg_enable_a/b=0, reg_store=0, rsp_valid=0. After release, the core is granted first.
- Write then read:
  - Core we=1, rd=5, wdata=0xDEADBEEF -> reg_store=1<<5 for exactly 1 cycle.
  - Then rs1=5, rs2=0 -> rsp_a=0xDEADBEEF, rsp_b=0, reg_enable_b=0 throughout.
- Same-transaction read and write: x7 preloaded with 0x11; request rs1=7, we=1, rd=7, wdata=0x22 -> rsp_a=0x11. The next read of x7 returns 0x22.
- Fairness: req_valid=2'b11 held for 6 transactions with rsp_ready=1 -> grant order core, debug, core, debug, core, debug; each response appears on the matching rsp_valid bit.
- x0 write: debug we=1, rd=0, wdata=0xFFFFFFFF -> reg_store stays 0. The response still issues, and a later read of x0 returns 0.
- Backpressure and reset:
  - rsp_ready=0 for 5 cycles -> rsp_valid, rsp_a and rsp_b are stable, and no req_ready is issued.
  - reset_n falls during ACCESS -> enables drop in the same cycle with no clock edge, and the FSM returns to IDLE.
